// File: rtl/mdu_sched.sv
// mdu_sched: sequences MULT/MULTU/DIV/DIVU through an external pipelined multiplier and an iterative divider
module mdu_sched #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic        flush_i,
  output logic        mul_valid_o,
  output logic        mul_signed_o,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  input  logic [63:0] mul_result_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_a_o,
  output logic [31:0] div_b_o,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] hilo_o
);
  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;
  state_t      state;
  logic [3:0]  cnt;
  logic [63:0] res;
  logic [31:0] a, b;
  logic        sgn;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      res   <= '0;
      a     <= '0;
      b     <= '0;
      sgn   <= 1'b0;
    end else if (flush_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          a   <= reg1_i;
          b   <= reg2_i;
          sgn <= ~op_i[0];
          if (!op_i[1]) begin
            state <= MUL_WAIT;
            cnt   <= 4'(MUL_LAT);
          end else if (reg2_i != '0) begin
            state <= DIV_WAIT;
          end else begin
            state <= DONE;
            res   <= '0;
          end
        end
        MUL_WAIT: if (cnt == '0) begin
          res   <= mul_result_i;
          state <= DONE;
        end else begin
          cnt <= cnt - 4'd1;
        end
        DIV_WAIT: if (div_ready_i) begin
          res   <= div_result_i;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // the counter only holds MUL_LAT during the first MUL_WAIT cycle
  assign mul_valid_o  = (state == MUL_WAIT) && (cnt == 4'(MUL_LAT));
  assign mul_signed_o = sgn;
  assign mul_a_o      = a;
  assign mul_b_o      = b;
  assign div_start_o  = state == DIV_WAIT;
  assign div_annul_o  = (state == DIV_WAIT) && flush_i && !rst_i;
  assign div_signed_o = sgn;
  assign div_a_o      = a;
  assign div_b_o      = b;
  assign stall_o      = !flush_i && (((state == IDLE) && start_i) || state == MUL_WAIT || state == DIV_WAIT);
  assign busy_o       = state != IDLE;
  assign done_o       = (state == DONE) && !flush_i;
  assign hilo_o       = done_o ? res : '0;
endmodule

// File: tb/tb_mdu_sched.sv
// tb_mdu_sched: directed cycle-by-cycle checks of mdu_sched with hand-computed expectations
module tb_mdu_sched;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] reg1 = '0, reg2 = '0;
  logic [63:0] mul_result = 64'hBAD0_BAD0_BAD0_BAD0, div_result = 64'hDEAD_DEAD_DEAD_DEAD;
  logic        div_ready = 1'b0;
  logic        mul_valid, mul_signed, div_start, div_annul, div_signed, stall, busy, done;
  logic [31:0] mul_a, mul_b, div_a, div_b;
  logic [63:0] hilo;
  int passed = 0, total = 0;
  localparam logic [63:0] GARBAGE = 64'hBAD0_BAD0_BAD0_BAD0;

  mdu_sched #(.MUL_LAT(2)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .reg1_i(reg1), .reg2_i(reg2),
    .flush_i(flush), .mul_valid_o(mul_valid), .mul_signed_o(mul_signed), .mul_a_o(mul_a),
    .mul_b_o(mul_b), .mul_result_i(mul_result), .div_start_o(div_start), .div_annul_o(div_annul),
    .div_signed_o(div_signed), .div_a_o(div_a), .div_b_o(div_b), .div_ready_i(div_ready),
    .div_result_i(div_result), .stall_o(stall), .busy_o(busy), .done_o(done), .hilo_o(hilo)
  );

  always #5 clk = ~clk;

  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " stall"}, 64'(stall), 0);
    chk({tag, " busy"}, 64'(busy), 0);
    chk({tag, " done"}, 64'(done), 0);
    chk({tag, " hilo"}, hilo, 0);
    chk({tag, " mul_valid"}, 64'(mul_valid), 0);
    chk({tag, " mul_signed"}, 64'(mul_signed), 0);
    chk({tag, " mul_a"}, 64'(mul_a), 0);
    chk({tag, " mul_b"}, 64'(mul_b), 0);
    chk({tag, " div_start"}, 64'(div_start), 0);
    chk({tag, " div_annul"}, 64'(div_annul), 0);
    chk({tag, " div_signed"}, 64'(div_signed), 0);
    chk({tag, " div_a"}, 64'(div_a), 0);
    chk({tag, " div_b"}, 64'(div_b), 0);
  endtask

  initial begin
    // reset
    adv(); rst = 1'b1;
    adv(); adv(); rst = 1'b0;
    settle();
    chk_all_zero("reset");

    // MULT -3 * 5
    adv(); start = 1'b1; op = 2'b00; reg1 = 32'hFFFF_FFFD; reg2 = 32'd5;
    settle();
    chk("mult c0 stall", 64'(stall), 1);
    chk("mult c0 busy", 64'(busy), 0);
    chk("mult c0 mul_valid", 64'(mul_valid), 0);
    adv(); settle();
    chk("mult c1 mul_valid", 64'(mul_valid), 1);
    chk("mult c1 mul_a", 64'(mul_a), 64'hFFFF_FFFD);
    chk("mult c1 mul_b", 64'(mul_b), 5);
    chk("mult c1 signed", 64'(mul_signed), 1);
    chk("mult c1 busy", 64'(busy), 1);
    adv(); settle();
    chk("mult c2 mul_valid", 64'(mul_valid), 0);
    chk("mult c2 stall", 64'(stall), 1);
    adv(); mul_result = 64'hFFFF_FFFF_FFFF_FFF1;
    settle();
    chk("mult c3 stall", 64'(stall), 1);
    chk("mult c3 done", 64'(done), 0);
    adv(); mul_result = GARBAGE;
    settle();
    chk("mult c4 done", 64'(done), 1);
    chk("mult c4 hilo", hilo, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("mult c4 stall", 64'(stall), 0);
    chk("mult c4 busy", 64'(busy), 1);
    adv(); start = 1'b0;
    settle();
    chk("mult c5 done", 64'(done), 0);
    chk("mult c5 hilo", hilo, 0);
    chk("mult c5 busy", 64'(busy), 0);

    // stray div_ready while idle is ignored
    adv(); div_ready = 1'b1;
    adv(); div_ready = 1'b0;
    settle();
    chk("stray ready busy", 64'(busy), 0);
    chk("stray ready done", 64'(done), 0);

    // DIVU 100 / 7, ready in cycle 34
    adv(); start = 1'b1; op = 2'b11; reg1 = 32'd100; reg2 = 32'd7;
    settle();
    chk("divu c0 stall", 64'(stall), 1);
    chk("divu c0 div_start", 64'(div_start), 0);
    for (int c = 1; c <= 34; c++) begin
      adv();
      if (c == 34) begin
        div_ready = 1'b1;
        div_result = {32'd2, 32'd14};
      end
      settle();
      chk($sformatf("divu c%0d div_start", c), 64'(div_start), 1);
      chk($sformatf("divu c%0d stall", c), 64'(stall), 1);
      chk($sformatf("divu c%0d done", c), 64'(done), 0);
    end
    chk("divu div_a", 64'(div_a), 100);
    chk("divu div_b", 64'(div_b), 7);
    chk("divu signed", 64'(div_signed), 0);
    adv(); div_ready = 1'b0; div_result = 64'hDEAD_DEAD_DEAD_DEAD;
    settle();
    chk("divu c35 done", 64'(done), 1);
    chk("divu c35 hilo", hilo, {32'd2, 32'd14});
    chk("divu c35 div_start", 64'(div_start), 0);
    chk("divu c35 stall", 64'(stall), 0);
    adv(); start = 1'b0;
    settle();
    chk("divu c36 done", 64'(done), 0);

    // DIV by zero
    adv(); start = 1'b1; op = 2'b10; reg1 = 32'd55; reg2 = 32'd0;
    settle();
    chk("div0 c0 stall", 64'(stall), 1);
    adv(); settle();
    chk("div0 c1 done", 64'(done), 1);
    chk("div0 c1 hilo", hilo, 0);
    chk("div0 c1 div_start", 64'(div_start), 0);
    chk("div0 c1 stall", 64'(stall), 0);
    adv(); start = 1'b0;
    settle();
    chk("div0 c2 busy", 64'(busy), 0);

    // DIV flushed in cycle 10, late ready ignored
    adv(); start = 1'b1; op = 2'b10; reg1 = 32'hFFFF_FFEC; reg2 = 32'd3;
    for (int c = 1; c <= 9; c++) adv();
    settle();
    chk("flush c9 div_start", 64'(div_start), 1);
    chk("flush c9 div_annul", 64'(div_annul), 0);
    chk("flush c9 signed", 64'(div_signed), 1);
    adv(); flush = 1'b1;
    settle();
    chk("flush c10 div_annul", 64'(div_annul), 1);
    chk("flush c10 stall", 64'(stall), 0);
    chk("flush c10 done", 64'(done), 0);
    adv(); flush = 1'b0; start = 1'b0;
    settle();
    chk("flush c11 busy", 64'(busy), 0);
    chk("flush c11 div_start", 64'(div_start), 0);
    chk("flush c11 div_annul", 64'(div_annul), 0);
    adv(); div_ready = 1'b1; div_result = 64'h1234_5678_9ABC_DEF0;
    settle();
    chk("flush c12 busy", 64'(busy), 0);
    adv(); div_ready = 1'b0;
    settle();
    chk("flush c13 done", 64'(done), 0);
    chk("flush c13 hilo", hilo, 0);
    chk("flush c13 busy", 64'(busy), 0);

    // MULT flushed in MUL_WAIT discards the product
    adv(); start = 1'b1; op = 2'b00; reg1 = 32'd3; reg2 = 32'd4;
    adv(); adv(); flush = 1'b1;
    settle();
    chk("mflush c2 stall", 64'(stall), 0);
    adv(); flush = 1'b0; start = 1'b0; mul_result = 64'd12;
    settle();
    chk("mflush c3 busy", 64'(busy), 0);
    adv(); mul_result = GARBAGE;
    settle();
    chk("mflush c4 done", 64'(done), 0);
    chk("mflush c4 busy", 64'(busy), 0);

    // reset during MUL_WAIT, then MULTU 0xFFFFFFFF * 2
    adv(); start = 1'b1; op = 2'b00; reg1 = 32'd7; reg2 = 32'd9;
    adv(); settle();
    chk("rmul c1 busy", 64'(busy), 1);
    adv(); rst = 1'b1; start = 1'b0;
    adv(); rst = 1'b0;
    settle();
    chk_all_zero("midreset");
    adv(); start = 1'b1; op = 2'b01; reg1 = 32'hFFFF_FFFF; reg2 = 32'd2;
    adv(); settle();
    chk("multu c1 mul_valid", 64'(mul_valid), 1);
    chk("multu c1 signed", 64'(mul_signed), 0);
    adv();
    adv(); mul_result = 64'h1_FFFF_FFFE;
    adv(); mul_result = GARBAGE;
    settle();
    chk("multu c4 done", 64'(done), 1);
    chk("multu c4 hilo", hilo, 64'h1_FFFF_FFFE);
    adv(); start = 1'b0;

    // MULT 6*7 then DIVU 50/8 with start held continuously
    adv(); start = 1'b1; op = 2'b00; reg1 = 32'd6; reg2 = 32'd7;
    adv(); adv();
    adv(); mul_result = 64'd42;
    adv(); mul_result = GARBAGE;
    settle();
    chk("b2b c4 done", 64'(done), 1);
    chk("b2b c4 hilo", hilo, 42);
    adv(); op = 2'b11; reg1 = 32'd50; reg2 = 32'd8;
    settle();
    chk("b2b c5 busy", 64'(busy), 0);
    chk("b2b c5 stall", 64'(stall), 1);
    chk("b2b c5 done", 64'(done), 0);
    adv(); div_ready = 1'b1; div_result = {32'd2, 32'd6};
    settle();
    chk("b2b c6 div_start", 64'(div_start), 1);
    chk("b2b c6 div_a", 64'(div_a), 50);
    chk("b2b c6 div_b", 64'(div_b), 8);
    adv(); div_ready = 1'b0;
    settle();
    chk("b2b c7 done", 64'(done), 1);
    chk("b2b c7 hilo", hilo, {32'd2, 32'd6});
    adv(); start = 1'b0;
    settle();
    chk("b2b c8 done", 64'(done), 0);
    chk("b2b c8 busy", 64'(busy), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mdu_sched.md
# mdu_sched

Multi-cycle multiply/divide scheduler in the EX stage. It accepts one MULT/MULTU/DIV/DIVU issue at a time from the EX ALU path and sequences a fixed-latency pipelined multiplier and the iterative start/ready divider. It raises a pipeline stall while the operation is in flight and returns the 64-bit {HI, LO} result for exactly one cycle. On a pipeline flush it cancels the in-flight operation.

## Interface
- `MUL_LAT`, default 2: multiplier latency in cycles, from the `mul_valid_o` cycle to the cycle `mul_result_i` is valid; legal range 1..15.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  EX holds a mul/div instruction; held high until `done_o` or flush.
- `op_i`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start_i` in IDLE.
- `reg1_i`, `reg2_i`  in  32 each  operands rs and rt; latched at issue.
- `flush_i`  in  1  pipeline flush; has priority over all other events.
- `mul_valid_o`  out  1  one-cycle issue pulse to the multiplier.
- `mul_signed_o`  out  1  selects a signed multiply.
- `mul_a_o`, `mul_b_o`  out  32 each  latched operands.
- `mul_result_i`  in  64  multiplier product.
- `div_start_o`  out  1  divider start; level signal.
- `div_annul_o`  out  1  divider cancel; one-cycle pulse.
- `div_signed_o`  out  1  selects a signed divide.
- `div_a_o`, `div_b_o`  out  32 each  latched operands.
- `div_ready_i`  in  1  divider result valid.
- `div_result_i`  in  64  divider result, {remainder, quotient}.
- `stall_o`  out  1  stall request to the pipeline.
- `busy_o`  out  1  state is not IDLE.
- `done_o`  out  1  `hilo_o` is valid this cycle.
- `hilo_o`  out  64  {HI, LO} result.

## Operation
- States: IDLE, MUL_WAIT, DIV_WAIT, DONE.
- **IDLE**, when `start_i` is high:
  - Latch `reg1_i`, `reg2_i`, and the signed flag (`op_i[0]==0`).
  - op MULT/MULTU: go to MUL_WAIT and load the counter with `MUL_LAT`.
  - op DIV/DIVU with `reg2_i != 0`: go to DIV_WAIT.
  - op DIV/DIVU with `reg2_i == 0`: go to DONE with result 64'h0. The divider is never started.
- **MUL_WAIT**:
  - `mul_valid_o` is high in the first MUL_WAIT cycle only.
  - The counter decrements every cycle.
  - When the counter reaches 0, capture `mul_result_i` into the result register and go to DONE.
- **DIV_WAIT**:
  - `div_start_o` stays high for every DIV_WAIT cycle.
  - In the cycle `div_ready_i` is high, capture `div_result_i` and go to DONE.
  - `div_start_o` is low from the DONE cycle onward.
- **DONE**:
  - `done_o` is 1, `hilo_o` equals the result register, and `stall_o` is 0.
  - The pipeline advances.
  - Next state is always IDLE. `start_i` seen in DONE belongs to the completing instruction and is ignored.
- `stall_o` is combinational: (state==IDLE & `start_i` & ~`flush_i`) | state==MUL_WAIT | state==DIV_WAIT. It is forced to 0 when `flush_i` is high.
- **Flush** (any state):
  - Next state is IDLE.
  - `done_o` is suppressed in the flush cycle.
  - If the state is DIV_WAIT, `div_annul_o` is high in that same cycle and `div_start_o` drops the next cycle.
  - A multiplier product still in flight is discarded: the counter is cleared and `mul_result_i` is not captured.
- `div_ready_i` arriving while not in DIV_WAIT is ignored.
- `hilo_o` is 0 whenever `done_o` is 0.
- Signed/unsigned behaviour is entirely delegated to the arithmetic units; the scheduler only forwards the flag.

## Timing
- **Reset** (`rst_i` sampled high):
  - State goes to IDLE; counter and result register are cleared.
  - All outputs are 0 from the following cycle: `stall_o`, `busy_o`, `done_o`, `hilo_o`, `mul_*_o`, `div_*_o`.
  - Reset mid-operation abandons the operation without asserting `div_annul_o`.
- **Multiply**: `start_i` in cycle 0; `mul_valid_o` in cycle 1; product valid in cycle 1+`MUL_LAT`; `done_o` in cycle 2+`MUL_LAT`. `stall_o` is high in cycles 0..1+`MUL_LAT`.
- **Divide**: `start_i` in cycle 0; `div_start_o` from cycle 1; `div_ready_i` in cycle k; `done_o` in cycle k+1.
- **Divide by zero**: `done_o` in cycle 1; `stall_o` high in cycle 0 only.
- Back-to-back issue: a new `start_i` is accepted at the earliest in the cycle after DONE.
- `busy_o` is registered: high in MUL_WAIT, DIV_WAIT and DONE.

## Test plan
- MULT, `reg1_i`=-3, `reg2_i`=5, `MUL_LAT`=2, bench multiplier returns the product after 2 cycles -> `mul_valid_o` in cycle 1; `done_o` in cycle 4 with `hilo_o`=64'hFFFFFFFF_FFFFFFF1; `stall_o` high in cycles 0-3.
- DIVU 100/7 with a divider model that asserts `div_ready_i` in cycle 34 -> `div_start_o` high in cycles 1-34; `done_o` in cycle 35 with `hilo_o`={32'd2, 32'd14}.
- DIV with `reg2_i`=0 -> `div_start_o` never high; `done_o` in cycle 1 with `hilo_o`=0.
- DIV in flight, `flush_i` in cycle 10 -> `div_annul_o` high in cycle 10; IDLE in cycle 11; `stall_o`=0 in cycle 10; `done_o` never asserted; a late `div_ready_i` is ignored.
- `rst_i` high during MUL_WAIT -> every output is 0 the next cycle; a following MULTU 0xFFFFFFFF*2 completes with `hilo_o`=64'h1_FFFFFFFE.
- MULT immediately followed by DIVU, `start_i` held continuously -> second issue accepted in the cycle after DONE; two distinct `done_o` pulses with correct results.
